// File: rtl/fir_sys_pkg.sv
// Shared helpers for the N-tap FIR engine: width derivation plus the
// round-half-up and saturation steps of the output stage.
package fir_sys_pkg;

    // Output-stage arithmetic runs at this width; ACC_W and OW must not exceed it.
    localparam int MAX_W = 64;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int acc_width(input int dw, input int cw, input int n_taps);
        return dw + cw + clog2(n_taps);
    endfunction

    function automatic logic signed [MAX_W-1:0] round_shift(
        input logic signed [MAX_W-1:0] v,
        input int                      shift
    );
        logic signed [MAX_W-1:0] half;
        if (shift == 0) return v;
        half = 64'sd1 <<< (shift - 1);
        return (v + half) >>> shift;
    endfunction

    function automatic logic signed [MAX_W-1:0] saturate(
        input logic signed [MAX_W-1:0] v,
        input int                      ow
    );
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        if (ow >= MAX_W) return v;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/fir_sys_n_if.sv
// Sample, coefficient and result signals of the FIR engine.
interface fir_sys_n_if #(
    parameter int DW = 8,
    parameter int CW = 8,
    parameter int OW = 16
) ();
    logic                 clr;
    logic                 coef_we;
    logic signed [CW-1:0] coef_in;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_data;
    logic                 out_valid;
    logic signed [OW-1:0] out_data;
    logic                 out_sat;
    logic                 out_warm;

    modport master (
        output clr, coef_we, coef_in, in_valid, in_data,
        input  in_ready, out_valid, out_data, out_sat, out_warm
    );

    modport slave (
        input  clr, coef_we, coef_in, in_valid, in_data,
        output in_ready, out_valid, out_data, out_sat, out_warm
    );
endinterface

// File: rtl/fir_tap.sv
// One transposed-form tap: holds coefficient c[k] and partial sum z[k];
// coefficients shift from the high tap towards tap 0.
module fir_tap #(
    parameter int DW    = 8,
    parameter int CW    = 8,
    parameter int ACC_W = 19
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_i,
    input  logic                    ce_i,
    input  logic                    coef_we_i,
    input  logic signed [CW-1:0]    coef_i,
    input  logic signed [DW-1:0]    x_i,
    input  logic signed [ACC_W-1:0] z_i,
    output logic signed [ACC_W-1:0] z_o,
    output logic signed [CW-1:0]    coef_o
);
    logic signed [CW-1:0]    c_q;
    logic signed [ACC_W-1:0] z_q;
    logic signed [ACC_W-1:0] z_d;

    assign z_d    = ACC_W'(c_q) * ACC_W'(x_i) + z_i;
    assign z_o    = z_q;
    assign coef_o = c_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q <= '0;
            z_q <= '0;
        end else begin
            if (coef_we_i) c_q <= coef_i;
            if (clr_i)     z_q <= '0;
            else if (ce_i) z_q <= z_d;
        end
    end
endmodule

// File: rtl/fir_sys_n.sv
// N-tap transposed-form FIR with sample enable, shift-loaded coefficients,
// warm-up flag and rounded/saturated output. One result per accepted sample.
module fir_sys_n
    import fir_sys_pkg::*;
#(
    parameter int N_TAPS = 8,
    parameter int DW     = 8,
    parameter int CW     = 8,
    parameter int OW     = 16,
    parameter int SHIFT  = 0
) (
    input  logic        clk,
    input  logic        rst,
    fir_sys_n_if.slave  bus
);
    localparam int                ACC_W   = acc_width(DW, CW, N_TAPS);
    localparam int                CNT_W   = clog2(N_TAPS + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(N_TAPS);

    logic                    ce;
    logic signed [CW-1:0]    c_w [1:N_TAPS];
    logic signed [ACC_W-1:0] z_w [1:N_TAPS];
    logic signed [CW-1:0]    c0_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [MAX_W-1:0] rnd;
    logic signed [MAX_W-1:0] clp;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    logic                    out_valid_q;
    logic                    out_sat_q;
    logic                    out_warm_q;
    logic signed [OW-1:0]    out_data_q;

    assign bus.in_ready = ~bus.coef_we & ~bus.clr;
    assign ce           = bus.in_valid & bus.in_ready;

    // Index N_TAPS is the virtual tap beyond the end: new coefficient in, zero partial sum.
    assign c_w[N_TAPS] = bus.coef_in;
    assign z_w[N_TAPS] = '0;

    generate
        for (genvar k = 1; k < N_TAPS; k++) begin : g_tap
            fir_tap #(.DW(DW), .CW(CW), .ACC_W(ACC_W)) u_tap (
                .clk       (clk),
                .rst       (rst),
                .clr_i     (bus.clr),
                .ce_i      (ce),
                .coef_we_i (bus.coef_we),
                .coef_i    (c_w[k+1]),
                .x_i       (bus.in_data),
                .z_i       (z_w[k+1]),
                .z_o       (z_w[k]),
                .coef_o    (c_w[k])
            );
        end
    endgenerate

    assign acc_d = ACC_W'(c0_q) * ACC_W'(bus.in_data) + z_w[1];
    assign rnd   = round_shift(MAX_W'(acc_d), SHIFT);
    assign clp   = saturate(rnd, OW);

    always_comb begin
        cnt_d = cnt_q;
        if (bus.clr)                     cnt_d = '0;
        else if (ce && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c0_q        <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
            out_warm_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (bus.coef_we) c0_q <= c_w[1];
            cnt_q       <= cnt_d;
            out_warm_q  <= (cnt_d == CNT_MAX);
            out_valid_q <= ce;
            // The result register doubles as the accumulator stage and holds between pulses.
            if (ce) begin
                out_data_q <= clp[OW-1:0];
                out_sat_q  <= (clp != rnd);
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.out_warm  = out_warm_q;
endmodule

// File: tb/tb_fir_sys_n.sv
// Bench for fir_sys_n: three 4-tap instances (OW16/SHIFT0, OW8/SHIFT0,
// OW16/SHIFT2) share one stimulus and are compared with a sample-history model.
module tb_fir_sys_n;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CW = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 clr;
    logic                 coef_we;
    logic                 in_valid;
    logic signed [CW-1:0] coef_in;
    logic signed [DW-1:0] in_data;

    fir_sys_n_if #(.DW(DW), .CW(CW), .OW(16)) bus0 ();
    fir_sys_n_if #(.DW(DW), .CW(CW), .OW(8))  bus1 ();
    fir_sys_n_if #(.DW(DW), .CW(CW), .OW(16)) bus2 ();

    assign bus0.clr = clr;  assign bus0.coef_we = coef_we;  assign bus0.coef_in = coef_in;
    assign bus0.in_valid = in_valid;  assign bus0.in_data = in_data;
    assign bus1.clr = clr;  assign bus1.coef_we = coef_we;  assign bus1.coef_in = coef_in;
    assign bus1.in_valid = in_valid;  assign bus1.in_data = in_data;
    assign bus2.clr = clr;  assign bus2.coef_we = coef_we;  assign bus2.coef_in = coef_in;
    assign bus2.in_valid = in_valid;  assign bus2.in_data = in_data;

    fir_sys_n #(.N_TAPS(N), .DW(DW), .CW(CW), .OW(16), .SHIFT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    fir_sys_n #(.N_TAPS(N), .DW(DW), .CW(CW), .OW(8),  .SHIFT(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    fir_sys_n #(.N_TAPS(N), .DW(DW), .CW(CW), .OW(16), .SHIFT(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    always #5 clk = ~clk;

    // Reference state: each accepted sample remembers the coefficients seen when it arrived.
    typedef int cvec_t [N];
    int     ow_m [3];
    int     sh_m [3];
    int     coef_m [N];
    cvec_t  snap_q [$];
    int     samp_q [$];
    int     cnt_m;
    longint exp_data [3];
    logic   exp_sat [3];
    logic   hold_ok;
    int     n_chk = 0;
    int     n_pass = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic longint floor_div(input longint v, input longint d);
        if (v >= 0) return v / d;
        return -((-v + d - 1) / d);
    endfunction

    task automatic ref_out(input int d, output longint val, output logic sat);
        longint y;
        longint hi;
        longint lo;
        y = 0;
        for (int k = 0; k < samp_q.size(); k++)
            y += longint'(snap_q[k][k]) * longint'(samp_q[k]);
        if (sh_m[d] > 0)
            y = floor_div(y + (64'sd1 <<< (sh_m[d] - 1)), 64'sd1 <<< sh_m[d]);
        hi  = (64'sd1 <<< (ow_m[d] - 1)) - 1;
        lo  = -hi - 1;
        sat = 1'b0;
        if (y > hi) begin y = hi; sat = 1'b1; end
        if (y < lo) begin y = lo; sat = 1'b1; end
        val = y;
    endtask

    task automatic reset_model();
        for (int k = 0; k < N; k++) coef_m[k] = 0;
        samp_q.delete();
        snap_q.delete();
        cnt_m = 0;
        for (int d = 0; d < 3; d++) begin
            exp_data[d] = 0;
            exp_sat[d]  = 1'b0;
        end
        hold_ok = 1'b1;
    endtask

    task automatic check_dut(input int d, input logic v, input longint data,
                             input logic sat, input logic warm, input logic expv);
        check($sformatf("dut%0d out_valid", d), v, expv);
        check($sformatf("dut%0d out_warm", d), warm, cnt_m == N);
        if (hold_ok) begin
            check($sformatf("dut%0d out_data", d), data, exp_data[d]);
            check($sformatf("dut%0d out_sat", d), sat, exp_sat[d]);
        end
    endtask

    task automatic check_all(input logic expv);
        check_dut(0, bus0.out_valid, longint'(bus0.out_data), bus0.out_sat, bus0.out_warm, expv);
        check_dut(1, bus1.out_valid, longint'(bus1.out_data), bus1.out_sat, bus1.out_warm, expv);
        check_dut(2, bus2.out_valid, longint'(bus2.out_data), bus2.out_sat, bus2.out_warm, expv);
    endtask

    // One clock: drive after the falling edge, update the model at the rising edge, check at the next falling edge.
    task automatic cycle(input logic v, input int x, input logic we, input int c, input logic cl);
        logic take;
        in_valid = v;
        in_data  = DW'(x);
        coef_we  = we;
        coef_in  = CW'(c);
        clr      = cl;
        take     = v & ~we & ~cl;
        #1;
        check("in_ready", {bus0.in_ready, bus1.in_ready, bus2.in_ready}, (we | cl) ? 3'b000 : 3'b111);
        @(posedge clk);
        if (cl) begin
            samp_q.delete();
            snap_q.delete();
            cnt_m   = 0;
            hold_ok = 1'b0;
        end
        if (we) begin
            for (int k = 0; k < N - 1; k++) coef_m[k] = coef_m[k+1];
            coef_m[N-1] = c;
        end
        if (take) begin
            samp_q.push_front(x);
            snap_q.push_front(coef_m);
            if (samp_q.size() > N) begin
                void'(samp_q.pop_back());
                void'(snap_q.pop_back());
            end
            if (cnt_m < N) cnt_m++;
            for (int d = 0; d < 3; d++) ref_out(d, exp_data[d], exp_sat[d]);
            hold_ok = 1'b1;
        end
        @(negedge clk);
        check_all(take);
    endtask

    task automatic load4(input int c0, input int c1, input int c2, input int c3);
        cycle(0, 0, 1, c0, 0);
        cycle(0, 0, 1, c1, 0);
        cycle(0, 0, 1, c2, 0);
        cycle(0, 0, 1, c3, 0);
    endtask

    task automatic async_reset();
        in_valid = 1'b0;
        coef_we  = 1'b0;
        clr      = 1'b0;
        #2 rst = 1'b1;
        #1;
        reset_model();
        check_all(1'b0);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all(1'b0);
    endtask

    initial begin
        ow_m = '{16, 8, 16};
        sh_m = '{0, 0, 2};
        in_valid = 1'b0; in_data = '0; coef_we = 1'b0; coef_in = '0; clr = 1'b0;
        reset_model();
        #3;
        check_all(1'b0);
        check("in_ready idle", {bus0.in_ready, bus1.in_ready, bus2.in_ready}, 3'b111);
        @(negedge clk);
        rst = 1'b0;

        // Coefficient write colliding with a sample, then the rest of 1,2,3,4
        cycle(1, 55, 1, 1, 0);
        cycle(0, 0, 1, 2, 0);
        cycle(0, 0, 1, 3, 0);
        cycle(0, 0, 1, 4, 0);

        // Impulse
        cycle(1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 0);

        // Step with two bubbles after the second sample
        cycle(0, 0, 0, 0, 1);
        cycle(1, 10, 0, 0, 0);
        cycle(1, 10, 0, 0, 0);
        cycle(0, 77, 0, 0, 0);
        cycle(0, 77, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 10, 0, 0, 0);

        // Clear mid-step: dropped sample, then restart from 10
        cycle(1, 10, 0, 0, 1);
        cycle(1, 10, 0, 0, 0);
        cycle(1, 10, 0, 0, 0);
        // Clear and coefficient write together
        cycle(1, 10, 1, 5, 1);
        cycle(1, 10, 0, 0, 0);

        // Rounding with only c[0] = 1
        load4(1, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(1, 6, 0, 0, 0);
        cycle(1, 5, 0, 0, 0);
        cycle(1, -6, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(1, 7, 0, 0, 0);
        cycle(1, -2, 0, 0, 0);
        cycle(1, -7, 0, 0, 0);

        // Saturation
        load4(127, 127, 127, 127);
        cycle(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cycle(1, 127, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, -128, 0, 0, 0);

        // Random streaming with occasional coefficient writes and clears
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)) - 128,
                  $urandom_range(0, 15) == 0, int'($urandom_range(0, 255)) - 128,
                  $urandom_range(0, 31) == 0);

        // Asynchronous reset mid-stream, then reload and replay the impulse
        load4(1, 2, 3, 4);
        cycle(1, 9, 0, 0, 0);
        cycle(1, -3, 0, 0, 0);
        async_reset();
        load4(1, 2, 3, 4);
        cycle(1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got t=%0t, expected finish before 200000", $time);
        $fatal(1);
    end
endmodule

// File: doc/fir_sys_n.md
# fir_sys_n

Parametrised N-tap transposed-form FIR engine, the next generation of the single-tap processing element. It adds a global sample enable, run-time coefficient loading, a warm-up flag, and output rounding/saturation. It sits between the parallel-IO sample port and the output formatter of the FIR datapath. One accepted input sample produces exactly one filtered output sample one cycle later.

## Interface
- `N_TAPS`, 8: number of taps, ≥2
- `DW`, 8: input sample width, signed two's complement
- `CW`, 8: coefficient width, signed
- `OW`, 16: output width
- `SHIFT`, 0: right-shift applied to the accumulator before output, 0 ≤ SHIFT < `ACC_W`
- `clk` in 1: sole clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `clr` in 1: synchronous clear of the delay line and warm-up count; coefficients are kept
- `coef_we` in 1: coefficient shift-load strobe
- `coef_in` in CW: coefficient data
- `in_valid` in 1: sample present
- `in_ready` out 1: sample accepted when `in_valid & in_ready`
- `in_data` in DW: input sample
- `out_valid` out 1: one-cycle pulse per result
- `out_data` out OW: rounded, saturated result
- `out_sat` out 1: `out_data` was clipped, qualified by `out_valid`
- `out_warm` out 1: at least `N_TAPS` samples accepted since the last reset or `clr`

## Operation
- `ACC_W` = DW + CW + clog2(N_TAPS). All products and partial sums are signed at full `ACC_W`, so internal overflow is impossible.
- Coefficient load. On `coef_we`: c[k] ← c[k+1] for k < N−1, and c[N−1] ← `coef_in`. After N writes, the first word written is c[0].
- `in_ready` = `~coef_we & ~clr`, combinational. A collision with either signal drops the sample, and the sender must hold it.
- Accept, ce = `in_valid & in_ready`. All of the following update only when ce is high:
  - z[N−1] ← c[N−1]·x
  - z[k] ← c[k]·x + z[k+1], for 1 ≤ k < N−1
  - acc ← c[0]·x + z[1]
  - Result: y[n] = Σ c[k]·x[n−k], where samples before the last reset or `clr` count as 0.
- Bubbles (ce low) freeze every z register. The filter works in sample time, not cycle time.
- Output stage, computed from acc:
  - If SHIFT > 0, add 2^(SHIFT−1), then arithmetic-shift right by SHIFT. This is round-half-up.
  - Saturate to [−2^(OW−1), 2^(OW−1)−1], and set `out_sat` when clipping occurs.
  - If OW ≥ the shifted width, sign-extend instead; `out_sat` is then always 0.
- Warm-up counter, clog2(N_TAPS+1) bits. It increments on ce and saturates at N_TAPS. `out_warm` = (count == N_TAPS), registered.
- `clr` zeroes z[], acc, and the count. It forces `out_valid` = 0 the next cycle. Coefficients are unchanged.
- `coef_we` during streaming changes coefficients immediately. No output is recomputed, and results around the change use mixed coefficients. This is legal, and the bench must not flag it.

## Timing
- Reset values: z[], acc, c[], count = 0; `out_valid`, `out_data`, `out_sat`, `out_warm` = 0; `in_ready` = 1 once `rst` is released, when idle.
- Latency: ce at cycle t → `out_valid` = 1 at t+1, with `out_data` and `out_sat` valid in the same cycle. Back-to-back ce gives continuous `out_valid`.
- `out_data` holds its value between pulses.
- `rst` asserted mid-stream clears everything asynchronously, including coefficients. An in-flight result is lost, with no `out_valid`.
- `clr` and `coef_we` in the same cycle: both act. The delay line is cleared and the coefficient shifts. No sample is accepted.
- `out_warm` rises in the cycle after the N-th ce, together with that sample's `out_valid`.

## Structure
- Package `fir_sys_pkg`:
  - function `clog2`
  - `ACC_W` derivation helper
  - saturate/round function (width-generic via parameters)
- Sub-module `fir_tap`: one tap holding c[k] and z[k], with inputs ce, coef shift-in, x, z_in and outputs z_out, coef shift-out. Instantiate it N−1 times via `generate`. Tap 0 plus the output stage live in the top level.

## Test plan
- Impulse, N=4, coefficients loaded in order 1,2,3,4, SHIFT=0, OW=16. Input x = 1,0,0,0,0 → `out_data` = 1,2,3,4,0 on consecutive `out_valid` pulses; `out_warm` rises with the 4th output.
- Step x=10 with the same coefficients → 10,30,60,100,100,…; insert two bubble cycles after the 2nd sample → identical value sequence, and `out_valid` gaps match the bubbles.
- Saturation, OW=8, SHIFT=0, coefficients all 127, x=127 sustained → outputs 16129, clipped to 127 with `out_sat`=1; x=−128 → −128 with `out_sat`=1.
- Rounding, SHIFT=2, single coefficient 1 (others 0):
  - x=6 → 2 (6/4 = 1.5 rounds up)
  - x=5 → 1
  - x=−6 → −1 (−1.5 rounds toward +∞)
- Collisions: `coef_we` with `in_valid` → `in_ready`=0, no `out_valid`, coefficients shifted. `clr` mid-stream of a step → next accepted sample gives 10, not 100, and `out_warm` drops.
- Async `rst` pulse between two clock edges mid-stream → all outputs 0 immediately; reloading coefficients and replaying the impulse gives 1,2,3,4.
